ks10_bus_arbiter: RTL and testbench
===================================

# ks10_bus_arbiter

Sequential bus arbiter between the three KS10 bus masters (CPU, console, Unibus adapter) and the memory controller. Grants one master at a time, forwards its address and write data to memory, and returns the memory's read data and acknowledge to that master. Optionally terminates cycles to nonexistent memory with an NXM indication. Every memory transaction in the system passes through this block.

## Interface
- NXM_CYCLES, 256: bus cycles without memACKI before a grant is terminated as NXM (range 4..65535).
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- cpuREQI / cslREQI / ubaREQI  in  1 each  master bus request, held high until ACK.
- cpuACKO / cslACKO / ubaACKO  out  1 each  one-cycle acknowledge to the granted master.
- cpuADDRI / cslADDRI / ubaADDRI  in  [0:35] each  master address word, including the KS10 read/write/IO flag bits.
- cpuDATAI / cslDATAI / ubaDATAI  in  [0:35] each  master write data.
- cpuDATAO / cslDATAO / ubaDATAO  out  [0:35] each  registered read data; updated only for the granted master.
- memREQO  out  1  memory request, high for the whole grant.
- memACKI  in  1  one-cycle memory acknowledge; memDATAI is valid in the same cycle.
- memDATAI  in  [0:35]  memory read data.
- memDATAO  out  [0:35]  write data of the granted master.
- arbADDRO  out  [0:35]  address of the granted master.
- arbGNT  out  [0:2]  one-hot grant: bit 0 = csl, bit 1 = uba, bit 2 = cpu.
- arbNXM  out  1  one-cycle pulse when a grant is terminated by timeout.

## Operation
- Fixed priority: console > Unibus > CPU. Priority is evaluated only in IDLE. An active grant is never pre-empted.
- States:
  - IDLE: no grant. If any REQ is high, latch the winner into arbGNT and go to BUSY.
  - BUSY: memREQO = 1. arbADDRO and memDATAO mux the granted master's inputs combinationally from the registered grant.
    - On memACKI: register memDATAI into the granted master's DATAO and go to ACK.
    - On timeout: go to ACK with DATAO = 0 and arbNXM pulsed.
  - ACK: granted master's ACKO = 1 for exactly this cycle; memREQO = 0. Go to RELEASE.
  - RELEASE: wait until the granted REQ is low, then clear arbGNT and go to IDLE.
- If the granted master drops REQ while in BUSY, the transaction still completes and ACK is still issued. A memory write is never cancelled.
- memACKI is ignored outside BUSY.
- Reset mid-operation: the state machine returns to IDLE immediately. Any in-flight memory cycle is abandoned; memory resets on the same reset.
- Reset values: all ACKO = 0, all DATAO = 0, memREQO = 0, memDATAO = 0, arbADDRO = 0, arbGNT = 000, arbNXM = 0.
- With no grant, arbADDRO and memDATAO are 0.

## Timing
- REQ sampled high at edge n → arbGNT and memREQO high after edge n.
- memACKI high at edge m → DATAO and ACKO valid after edge m, for one cycle.
- Requester drops REQ on the cycle following ACK → IDLE after the next edge.
- Minimum transaction is 4 cycles: IDLE, BUSY, ACK, RELEASE. Back-to-back grants to different masters are therefore 4 cycles apart.
- Timeout counter:
  - Cleared on entry to BUSY; increments each BUSY cycle.
  - On reaching NXM_CYCLES−1 with no memACKI, the next edge enters ACK with NXM.
  - If memACKI coincides with the terminal count, the acknowledge wins and arbNXM stays 0.
  - The counter is 16 bits and saturates; it never wraps.

## Configuration
- KS10_ARB_NXM_TIMEOUT_EN defined: the timeout counter and arbNXM are implemented as described above.
- Not defined:
  - BUSY waits indefinitely for memACKI.
  - arbNXM is tied to 0 and NXM_CYCLES is unused.
  - No counter logic is synthesized.

## Structure
- The shared package ks10_bus_pkg holds:
  - the 36-bit word width constant;
  - the arbiter state enum (IDLE, BUSY, ACK, RELEASE);
  - grant index constants (GNT_CSL = 0, GNT_UBA = 1, GNT_CPU = 2).
- One sub-module, ks10_nxm_timer: enable, clear, saturating 16-bit count and terminal-count flag. It is instantiated only under KS10_ARB_NXM_TIMEOUT_EN.

## Test plan
- CPU read: cpuREQI = 1 with cpuADDRI = 36'o000000001000; memory answers memACKI after 3 cycles with 36'o123456701234 → cpuDATAO = 36'o123456701234, cpuACKO is a single-cycle pulse, arbGNT returns to 000.
- Simultaneous requests: all three REQs raised on the same edge → grants occur in order csl, uba, cpu, each with arbGNT one-hot, and no two ACKO pulses overlap.
- No pre-emption: cslREQI rises while the CPU is in BUSY → the CPU cycle completes first, and the console is granted 2 cycles after the CPU drops REQ.
- NXM (macro defined, NXM_CYCLES = 8): memACKI is never asserted → after 8 BUSY cycles, arbNXM pulses once, ubaACKO pulses, and ubaDATAO = 0. Repeat with memACKI on the terminal cycle → no arbNXM.
- Reset mid-BUSY: drive rst_n low during a grant → all outputs go to their reset values asynchronously, and a new request after release is granted normally.

Source files
------------

// File: rtl/ks10_bus_pkg.sv
// Shared types and constants for the KS10 bus arbiter: word width, arbiter
// state encoding, grant bit positions and the fixed-priority winner picker.
package ks10_bus_pkg;

    localparam int WORD_W = 36;

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } arbStateT;

    localparam int GNT_CSL = 0;
    localparam int GNT_UBA = 1;
    localparam int GNT_CPU = 2;

    typedef logic [0:2] gntT;

    // Fixed priority: console over Unibus over CPU.
    function automatic gntT pickWinner(input logic cslReq, input logic ubaReq,
                                       input logic cpuReq);
        gntT g;
        g = '0;
        if (cslReq)
            g[GNT_CSL] = 1'b1;
        else if (ubaReq)
            g[GNT_UBA] = 1'b1;
        else if (cpuReq)
            g[GNT_CPU] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/ks10_nxm_timer.sv
// Saturating 16-bit bus-cycle counter used to detect nonexistent memory.
// tc is raised while enabled and the count equals TERMINAL.
module ks10_nxm_timer #(
    parameter logic [15:0] TERMINAL = 16'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != 16'hFFFF)
            count <= count + 16'd1;
    end

    assign tc = enable && (count == TERMINAL);

endmodule

// File: rtl/ks10_bus_arbiter.sv
// KS10 bus arbiter: grants CPU, console or Unibus adapter to memory one at a
// time. Define KS10_ARB_NXM_TIMEOUT_EN to build the nonexistent-memory timeout.
import ks10_bus_pkg::*;

module ks10_bus_arbiter #(
    parameter int NXM_CYCLES = 256
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     cpuREQI,
    input  logic     cslREQI,
    input  logic     ubaREQI,
    output logic     cpuACKO,
    output logic     cslACKO,
    output logic     ubaACKO,
    input  word_t    cpuADDRI,
    input  word_t    cslADDRI,
    input  word_t    ubaADDRI,
    input  word_t    cpuDATAI,
    input  word_t    cslDATAI,
    input  word_t    ubaDATAI,
    output word_t    cpuDATAO,
    output word_t    cslDATAO,
    output word_t    ubaDATAO,
    output logic     memREQO,
    input  logic     memACKI,
    input  word_t    memDATAI,
    output word_t    memDATAO,
    output word_t    arbADDRO,
    output gntT      arbGNT,
    output logic     arbNXM,
    output arbStateT arbState
);

    // Handshake: a master holds REQ until it sees its one-cycle ACK, and the
    // grant is only released once that master has dropped REQ again.

    arbStateT state, nextState;
    gntT      gnt, reqVec, ackVec;
    logic     grantedReq, timeout;
    word_t    cpuData, cslData, ubaData, captureWord;

    if (NXM_CYCLES < 4 || NXM_CYCLES > 65535) begin : gBadNxmCycles
        $error("NXM_CYCLES must be in 4..65535");
    end

    assign reqVec     = {cslREQI, ubaREQI, cpuREQI};
    assign grantedReq = |(gnt & reqVec);

`ifdef KS10_ARB_NXM_TIMEOUT_EN
    logic nxmPulse;

    ks10_nxm_timer #(
        .TERMINAL(16'(NXM_CYCLES - 1))
    ) uNxmTimer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != BUSY),
        .enable(state == BUSY),
        .tc    (timeout)
    );

    // A memory acknowledge on the terminal cycle beats the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nxmPulse <= 1'b0;
        else
            nxmPulse <= (state == BUSY) && timeout && !memACKI;
    end

    assign arbNXM = nxmPulse;
`else
    assign timeout = 1'b0;
    assign arbNXM  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (|reqVec) nextState = BUSY;
            BUSY:    if (memACKI || timeout) nextState = ACK;
            ACK:     nextState = RELEASE;
            RELEASE: if (!grantedReq) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        memREQO  = (state == BUSY);
        ackVec   = (state == ACK) ? gnt : '0;
        arbADDRO = '0;
        memDATAO = '0;
        if (gnt[GNT_CSL]) begin
            arbADDRO = cslADDRI;
            memDATAO = cslDATAI;
        end else if (gnt[GNT_UBA]) begin
            arbADDRO = ubaADDRI;
            memDATAO = ubaDATAI;
        end else if (gnt[GNT_CPU]) begin
            arbADDRO = cpuADDRI;
            memDATAO = cpuDATAI;
        end
    end

    assign {cslACKO, ubaACKO, cpuACKO} = ackVec;
    assign arbState = state;

    // A timed-out cycle returns zero to the master.
    assign captureWord = memACKI ? memDATAI : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt     <= '0;
            cslData <= '0;
            ubaData <= '0;
            cpuData <= '0;
        end else begin
            unique case (state)
                IDLE: gnt <= pickWinner(cslREQI, ubaREQI, cpuREQI);
                BUSY: begin
                    if (memACKI || timeout) begin
                        if (gnt[GNT_CSL]) cslData <= captureWord;
                        if (gnt[GNT_UBA]) ubaData <= captureWord;
                        if (gnt[GNT_CPU]) cpuData <= captureWord;
                    end
                end
                RELEASE: if (!grantedReq) gnt <= '0;
                default: ;
            endcase
        end
    end

    assign arbGNT   = gnt;
    assign cslDATAO = cslData;
    assign ubaDATAO = ubaData;
    assign cpuDATAO = cpuData;

endmodule

// File: tb/tb_ks10_bus_arbiter.sv
// Self-checking bench for ks10_bus_arbiter: expected read data is queued when
// memory answers and popped when the granted master sees its acknowledge.
module tb_ks10_bus_arbiter;
    import ks10_bus_pkg::*;

    localparam int NXM = 8;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    gntT      reqs;
    word_t    addrs[3];
    word_t    wdata[3];
    logic     cpuACKO, cslACKO, ubaACKO, memREQO, memACKI, arbNXM;
    word_t    cpuDATAO, cslDATAO, ubaDATAO, memDATAI, memDATAO, arbADDRO;
    gntT      arbGNT, acks;
    arbStateT arbState;

    int tests = 0;
    int fails = 0;
    int cycNo = 0;
    logic [35:0] exp_q[$];
    word_t expData[3];

    ks10_bus_arbiter #(.NXM_CYCLES(NXM)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpuREQI(reqs[2]), .cslREQI(reqs[0]), .ubaREQI(reqs[1]),
        .cpuACKO(cpuACKO), .cslACKO(cslACKO), .ubaACKO(ubaACKO),
        .cpuADDRI(addrs[2]), .cslADDRI(addrs[0]), .ubaADDRI(addrs[1]),
        .cpuDATAI(wdata[2]), .cslDATAI(wdata[0]), .ubaDATAI(wdata[1]),
        .cpuDATAO(cpuDATAO), .cslDATAO(cslDATAO), .ubaDATAO(ubaDATAO),
        .memREQO(memREQO), .memACKI(memACKI), .memDATAI(memDATAI),
        .memDATAO(memDATAO), .arbADDRO(arbADDRO), .arbGNT(arbGNT),
        .arbNXM(arbNXM), .arbState(arbState)
    );

    assign acks = {cslACKO, ubaACKO, cpuACKO};

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cycNo <= cycNo + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Drivers
    function automatic word_t randWord();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    function automatic word_t dataOf(input int idx);
        case (idx)
            0:       return cslDATAO;
            1:       return ubaDATAO;
            default: return cpuDATAO;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic waitMemReq(output bit ok, output int startCyc);
        ok = 1'b0;
        startCyc = 0;
        for (int i = 0; i < 64; i++) begin
            if (memREQO) begin
                ok = 1'b1;
                startCyc = cycNo;
                return;
            end
            cyc();
        end
    endtask

    // Memory model: answers delay cycles after the first BUSY cycle.
    task automatic memRespond(input int delay, input word_t data, input bit doAck,
                              output bit ok, output int startCyc);
        waitMemReq(ok, startCyc);
        if (!ok) return;
        repeat (delay) cyc();
        if (doAck) begin
            memACKI  = 1'b1;
            memDATAI = data;
            exp_q.push_back(data);
        end
        cyc();
        memACKI  = 1'b0;
        memDATAI = randWord();
    endtask

    task automatic test_reset();
        reqs = '0;
        memACKI = 1'b0;
        memDATAI = randWord();
        for (int i = 0; i < 3; i++) begin
            addrs[i] = randWord();
            wdata[i] = randWord();
            expData[i] = '0;
        end
        rst_n = 1'b0;
        #12;
        tests++;
        if ({memREQO, arbNXM, acks} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 00000", {memREQO, arbNXM, acks});
        end
        tests++;
        if (arbGNT !== 3'b000 || arbState !== IDLE) begin
            fails++;
            $display("FAIL reset_gnt: got gnt=%b state=%0d required 000/0", arbGNT, arbState);
        end
        tests++;
        if (arbADDRO !== '0 || memDATAO !== '0) begin
            fails++;
            $display("FAIL reset_bus: got addr=%o data=%o required 0/0", arbADDRO, memDATAO);
        end
        tests++;
        if ({cslDATAO, ubaDATAO, cpuDATAO} !== '0) begin
            fails++;
            $display("FAIL reset_datao: got %o %o %o required 0", cslDATAO, ubaDATAO, cpuDATAO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_stray_ack();
        memACKI = 1'b1;
        memDATAI = randWord();
        cyc();
        memACKI = 1'b0;
        cyc();
        tests++;
        if (acks !== 3'b000 || arbState !== IDLE || memREQO !== 1'b0) begin
            fails++;
            $display("FAIL stray_ack: got acks=%b state=%0d req=%b required 000/0/0", acks, arbState, memREQO);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (dataOf(i) !== expData[i]) begin
                fails++;
                $display("FAIL stray_ack_data%0d: got %o required %o", i, dataOf(i), expData[i]);
            end
        end
    endtask

    task automatic test_cpu_read();
        bit ok;
        int st;
        logic [35:0] e;
        addrs[2] = 36'o000000001000;
        wdata[2] = randWord();
        reqs = 3'b001;
        cyc();
        tests++;
        if (arbGNT !== 3'b001 || memREQO !== 1'b1) begin
            fails++;
            $display("FAIL cpu_grant: got gnt=%b req=%b required 001/1", arbGNT, memREQO);
        end
        tests++;
        if (arbADDRO !== addrs[2] || memDATAO !== wdata[2]) begin
            fails++;
            $display("FAIL cpu_mux: got addr=%o data=%o required %o/%o", arbADDRO, memDATAO, addrs[2], wdata[2]);
        end
        memRespond(3, 36'o123456701234, 1'b1, ok, st);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL cpu_memreq: got no memREQO required memREQO within 64 cycles");
        end
        tests++;
        if (acks !== 3'b001 || memREQO !== 1'b0) begin
            fails++;
            $display("FAIL cpu_ack: got acks=%b req=%b required 001/0", acks, memREQO);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        expData[2] = e;
        tests++;
        if (cpuDATAO !== e) begin
            fails++;
            $display("FAIL cpu_data: got %o required %o", cpuDATAO, e);
        end
        cyc();
        reqs = 3'b000;
        tests++;
        if (acks !== 3'b000 || arbGNT !== 3'b001) begin
            fails++;
            $display("FAIL cpu_pulse: got acks=%b gnt=%b required 000/001", acks, arbGNT);
        end
        cyc();
        tests++;
        if (arbGNT !== 3'b000 || arbADDRO !== '0 || arbState !== IDLE) begin
            fails++;
            $display("FAIL cpu_release: got gnt=%b addr=%o state=%0d required 000/0/0", arbGNT, arbADDRO, arbState);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int st;
        gntT who;
        logic [35:0] e;
        for (int i = 0; i < 3; i++) addrs[i] = randWord();
        reqs = 3'b111;
        for (int k = 0; k < 3; k++) begin
            who = 3'b100 >> k;
            memRespond($urandom_range(0, 3), randWord(), 1'b1, ok, st);
            tests++;
            if (!ok || acks !== who || arbGNT !== who || arbADDRO !== addrs[k]) begin
                fails++;
                $display("FAIL simul_order%0d: got ok=%b acks=%b gnt=%b addr=%o required 1/%b/%b/%o",
                         k, ok, acks, arbGNT, arbADDRO, who, who, addrs[k]);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
            expData[k] = e;
            for (int j = 0; j < 3; j++) begin
                tests++;
                if (dataOf(j) !== expData[j]) begin
                    fails++;
                    $display("FAIL simul_data%0d_%0d: got %o required %o", k, j, dataOf(j), expData[j]);
                end
            end
            cyc();
            reqs[k] = 1'b0;
            tests++;
            if (acks !== 3'b000) begin
                fails++;
                $display("FAIL simul_overlap%0d: got acks=%b required 000", k, acks);
            end
        end
        cyc();
    endtask

    task automatic test_no_preempt();
        bit ok;
        int st;
        logic [35:0] e;
        reqs = 3'b001;
        waitMemReq(ok, st);
        cyc();
        reqs[0] = 1'b1;
        cyc();
        tests++;
        if (arbGNT !== 3'b001 || !ok) begin
            fails++;
            $display("FAIL preempt_busy: got gnt=%b required 001", arbGNT);
        end
        memRespond(2, randWord(), 1'b1, ok, st);
        tests++;
        if (acks !== 3'b001) begin
            fails++;
            $display("FAIL preempt_ack: got acks=%b required 001", acks);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        expData[2] = e;
        tests++;
        if (cpuDATAO !== e) begin
            fails++;
            $display("FAIL preempt_data: got %o required %o", cpuDATAO, e);
        end
        cyc();
        reqs[2] = 1'b0;
        cyc();
        tests++;
        if (arbGNT !== 3'b000) begin
            fails++;
            $display("FAIL preempt_gap: got gnt=%b required 000", arbGNT);
        end
        cyc();
        tests++;
        if (arbGNT !== 3'b100) begin
            fails++;
            $display("FAIL preempt_csl: got gnt=%b required 100", arbGNT);
        end
        memRespond(0, randWord(), 1'b1, ok, st);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        expData[0] = e;
        tests++;
        if (acks !== 3'b100 || cslDATAO !== e) begin
            fails++;
            $display("FAIL preempt_csl_data: got acks=%b data=%o required 100/%o", acks, cslDATAO, e);
        end
        cyc();
        reqs = 3'b000;
        cyc();
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int st1, st2;
        logic [35:0] e;
        reqs = 3'b011;
        memRespond(0, randWord(), 1'b1, ok1, st1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        expData[1] = e;
        tests++;
        if (ubaACKO !== 1'b1 || ubaDATAO !== e) begin
            fails++;
            $display("FAIL b2b_uba: got ack=%b data=%o required 1/%o", ubaACKO, ubaDATAO, e);
        end
        cyc();
        reqs[1] = 1'b0;
        memRespond(0, randWord(), 1'b1, ok2, st2);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        expData[2] = e;
        tests++;
        if (cpuACKO !== 1'b1 || cpuDATAO !== e) begin
            fails++;
            $display("FAIL b2b_cpu: got ack=%b data=%o required 1/%o", cpuACKO, cpuDATAO, e);
        end
        tests++;
        if (!ok1 || !ok2 || st2 - st1 !== 4) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d cycles required 4", st2 - st1);
        end
        cyc();
        reqs = 3'b000;
        cyc();
    endtask

    task automatic test_nxm();
        bit ok;
        int st, n;
        logic [35:0] e;
        reqs = 3'b010;
`ifdef KS10_ARB_NXM_TIMEOUT_EN
        waitMemReq(ok, st);
        n = 1;
        while (n < 100) begin
            cyc();
            if (!memREQO) break;
            n++;
        end
        tests++;
        if (!ok || n !== NXM) begin
            fails++;
            $display("FAIL nxm_cycles: got %0d BUSY cycles required %0d", n, NXM);
        end
        expData[1] = '0;
        tests++;
        if (arbNXM !== 1'b1 || acks !== 3'b010 || ubaDATAO !== '0) begin
            fails++;
            $display("FAIL nxm_term: got nxm=%b acks=%b data=%o required 1/010/0", arbNXM, acks, ubaDATAO);
        end
        cyc();
        reqs = 3'b000;
        tests++;
        if (arbNXM !== 1'b0) begin
            fails++;
            $display("FAIL nxm_pulse: got nxm=%b required 0", arbNXM);
        end
        cyc();
        reqs = 3'b010;
        memRespond(NXM - 1, randWord(), 1'b1, ok, st);
`else
        memRespond(20, randWord(), 1'b1, ok, st);
`endif
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        expData[1] = e;
        tests++;
        if (!ok || arbNXM !== 1'b0 || ubaACKO !== 1'b1 || ubaDATAO !== e) begin
            fails++;
            $display("FAIL nxm_ackwins: got nxm=%b ack=%b data=%o required 0/1/%o", arbNXM, ubaACKO, ubaDATAO, e);
        end
        cyc();
        reqs = 3'b000;
        cyc();
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        int st;
        logic [35:0] e;
        reqs = 3'b001;
        waitMemReq(ok, st);
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) expData[i] = '0;
        tests++;
        if (!ok || memREQO !== 1'b0 || arbGNT !== 3'b000 || arbState !== IDLE) begin
            fails++;
            $display("FAIL rst_busy_ctrl: got req=%b gnt=%b state=%0d required 0/000/0", memREQO, arbGNT, arbState);
        end
        tests++;
        if (arbADDRO !== '0 || memDATAO !== '0 || {cslDATAO, ubaDATAO, cpuDATAO} !== '0 || acks !== 3'b000) begin
            fails++;
            $display("FAIL rst_busy_bus: got addr=%o wdata=%o cpuData=%o acks=%b required 0", arbADDRO, memDATAO, cpuDATAO, acks);
        end
        reqs = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        reqs = 3'b100;
        memRespond(1, randWord(), 1'b1, ok, st);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        expData[0] = e;
        tests++;
        if (!ok || acks !== 3'b100 || cslDATAO !== e || cpuDATAO !== expData[2]) begin
            fails++;
            $display("FAIL rst_recover: got acks=%b data=%o required 100/%o", acks, cslDATAO, e);
        end
        cyc();
        reqs = 3'b000;
        cyc();
    endtask

    initial begin
        test_reset();
        test_stray_ack();
        test_cpu_read();
        test_simultaneous();
        test_no_preempt();
        test_back_to_back();
        test_nxm();
        test_reset_mid_busy();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
